// File: rtl/cnn_maxpool2x2_col_pkg.sv
// Shared FP16 types, pooling FSM states and the FP16 compare helpers used by
// the 2x2 column max-pool stage.
package cnn_pool_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    WAIT_SECOND
  } pool_state_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;

  // Maps sign-magnitude FP16 onto an unsigned-comparable ordering key.
  function automatic logic [15:0] fp16_key(input fp16_t x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  // Returns b only when strictly greater; both signed zeros count as equal,
  // so any tie resolves to the earlier operand a.
  function automatic fp16_t fp16_max2(input fp16_t a, input fp16_t b);
    if ((a[14:0] == 15'd0) && (b[14:0] == 15'd0)) begin
      return a;
    end
    return (fp16_key(b) > fp16_key(a)) ? b : a;
  endfunction

endpackage

// File: rtl/cnn_maxpool2x2_col_if.sv
// Column-stream bus between the conv stage, the max-pool stage and the next
// layer buffer; the pool stage is the slave.
interface cnn_maxpool2x2_col_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_SIZE    = 24
);
  localparam int POOL_SIZE = IN_SIZE / 2;
  localparam int COL_W     = $clog2(IN_SIZE + 1);

  logic                  start;
  logic                  in_valid;
  logic [COL_W-1:0]      in_col;
  logic [DATA_WIDTH-1:0] in_data [IN_SIZE];
  logic                  out_valid;
  logic [COL_W-1:0]      out_col;
  logic [DATA_WIDTH-1:0] out_data [POOL_SIZE];
  logic                  frame_done;
  logic                  col_error;

  modport master (
    output start, in_valid, in_col, in_data,
    input  out_valid, out_col, out_data, frame_done, col_error
  );

  modport slave (
    input  start, in_valid, in_col, in_data,
    output out_valid, out_col, out_data, frame_done, col_error
  );
endinterface

// File: rtl/cnn_maxpool2x2_col_fp16_max4.sv
// Combinational FP16 4-input max; ties resolve to the earliest operand in
// a, b, c, d order.
module fp16_max4
  import cnn_pool_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  input  fp16_t c_i,
  input  fp16_t d_i,
  output fp16_t y_o
);
  fp16_t max_ab;
  fp16_t max_cd;

  assign max_ab = fp16_max2(a_i, b_i);
  assign max_cd = fp16_max2(c_i, d_i);
  assign y_o    = fp16_max2(max_ab, max_cd);
endmodule

// File: rtl/cnn_maxpool2x2_col.sv
// 2x2/stride-2 FP16 max-pool over conv output columns, one pooled column per
// column pair. Optional fused ReLU when CNN_MAXPOOL_RELU_EN is defined.
module cnn_maxpool2x2_col
  import cnn_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_SIZE    = 24
) (
  input logic                  clk,
  input logic                  rst,
  cnn_maxpool2x2_col_if.slave  pool_if
);
  localparam int POOL_SIZE = IN_SIZE / 2;
  localparam int COL_W     = $clog2(IN_SIZE + 1);

  if ((IN_SIZE % 2) != 0) begin : g_bad_in_size
    $error("cnn_maxpool2x2_col: IN_SIZE must be even");
  end
  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("cnn_maxpool2x2_col: only DATA_WIDTH 16 is supported");
  end

  pool_state_t      state_q, state_d;
  logic [COL_W-1:0] exp_col_q, exp_col_d;
  logic             col_error_q, col_error_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  fp16_t            out_data_q [POOL_SIZE];
  fp16_t            out_data_d [POOL_SIZE];
  fp16_t            col_buf_q  [IN_SIZE];
  fp16_t            pooled     [POOL_SIZE];
  fp16_t            pooled_act [POOL_SIZE];
  logic             buf_load;
  logic             col_match;

  for (genvar p = 0; p < POOL_SIZE; p++) begin : g_pool
    fp16_max4 u_max4 (
      .a_i (col_buf_q[2*p]),
      .b_i (col_buf_q[2*p+1]),
      .c_i (pool_if.in_data[2*p]),
      .d_i (pool_if.in_data[2*p+1]),
      .y_o (pooled[p])
    );
`ifdef CNN_MAXPOOL_RELU_EN
    assign pooled_act[p] = pooled[p][15] ? FP16_POS_ZERO : pooled[p];
`else
    assign pooled_act[p] = pooled[p];
`endif
  end

  assign col_match = pool_if.in_valid && (pool_if.in_col == exp_col_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    exp_col_d    = exp_col_q;
    col_error_d  = col_error_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_col_d    = out_col_q;
    out_data_d   = out_data_q;
    buf_load     = 1'b0;

    if (pool_if.start) begin
      state_d     = WAIT_FIRST;
      exp_col_d   = COL_W'(1);
      col_error_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (col_match) begin
            buf_load  = 1'b1;
            exp_col_d = exp_col_q + 1'b1;
            state_d   = WAIT_SECOND;
          end else if (pool_if.in_valid) begin
            col_error_d = 1'b1;
          end
        end
        WAIT_SECOND: begin
          if (col_match) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled_act;
            out_col_d   = (pool_if.in_col >> 1) - 1'b1;
            exp_col_d   = exp_col_q + 1'b1;
            if (exp_col_q == COL_W'(IN_SIZE)) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = WAIT_FIRST;
            end
          end else if (pool_if.in_valid) begin
            col_error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      exp_col_q    <= COL_W'(1);
      col_error_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_col_q    <= '0;
      out_data_q   <= '{default: FP16_POS_ZERO};
    end else begin
      state_q      <= state_d;
      exp_col_q    <= exp_col_d;
      col_error_q  <= col_error_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_col_q    <= out_col_d;
      out_data_q   <= out_data_d;
    end
  end

  // NOTE: the column buffer is left unreset; it is only read in WAIT_SECOND, after a load.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      col_buf_q <= pool_if.in_data;
    end
  end

  assign pool_if.out_valid  = out_valid_q;
  assign pool_if.out_col    = out_col_q;
  assign pool_if.out_data   = out_data_q;
  assign pool_if.frame_done = frame_done_q;
  assign pool_if.col_error  = col_error_q;

endmodule

// File: tb/tb_cnn_maxpool2x2_col.sv
// Scoreboard bench for cnn_maxpool2x2_col: a real-valued pooling model queues
// expected columns, a negedge monitor pops and compares them.
module tb_cnn_maxpool2x2_col;
  localparam int IN   = 24;
  localparam int POOL = IN / 2;

  typedef logic [15:0] col_t [IN];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_maxpool2x2_col_if #(.DATA_WIDTH(16), .IN_SIZE(IN)) bus ();

  cnn_maxpool2x2_col #(.DATA_WIDTH(16), .IN_SIZE(IN)) dut (
    .clk     (clk),
    .rst     (rst),
    .pool_if (bus)
  );

  int checks = 0;
  int errors = 0;

  int          exp_col_q  [$];
  bit          exp_done_q [$];
  logic [15:0] exp_data_q [$];

  bit          m_active = 1'b0;
  bit          m_err    = 1'b0;
  int          m_exp    = 1;
  col_t        m_buf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real fp16_val(input logic [15:0] x);
    int  e;
    int  m;
    real v;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 0) v = real'(m) * (2.0 ** (-24));
    else        v = real'(1024 + m) * (2.0 ** (e - 25));
    return x[15] ? -v : v;
  endfunction

  // First strictly-largest value in listed order; -0.0 and +0.0 compare equal as reals.
  function automatic logic [15:0] ref_pool(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
    logic [15:0] ops [4];
    logic [15:0] best;
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    best = ops[0];
    for (int i = 1; i < 4; i++) begin
      if (fp16_val(ops[i]) > fp16_val(best)) best = ops[i];
    end
`ifdef CNN_MAXPOOL_RELU_EN
    if (best[15]) best = 16'h0000;
`endif
    return best;
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] v;
    v[15]    = 1'($urandom);
    v[14:10] = 5'($urandom_range(0, 30));
    v[9:0]   = 10'($urandom);
    return v;
  endfunction

  function automatic col_t rand_col();
    col_t d;
    for (int r = 0; r < IN; r++) d[r] = rand_fp16();
    return d;
  endfunction

  function automatic col_t ramp_col(input int c);
    col_t d;
    for (int r = 0; r < IN; r++) d[r] = 16'h3C00 + 16'(c);
    return d;
  endfunction

  task automatic model_col(input int col, input col_t d);
    if (!m_active) return;
    if (col != m_exp) begin
      m_err = 1'b1;
      return;
    end
    if ((m_exp % 2) == 1) begin
      m_buf = d;
    end else begin
      exp_col_q.push_back(col / 2 - 1);
      exp_done_q.push_back(col == IN);
      for (int p = 0; p < POOL; p++)
        exp_data_q.push_back(ref_pool(m_buf[2*p], m_buf[2*p+1], d[2*p], d[2*p+1]));
      if (col == IN) m_active = 1'b0;
    end
    m_exp++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_col(input int col, input col_t d);
    bus.in_valid = 1'b1;
    bus.in_col   = 5'(col);
    bus.in_data  = d;
    model_col(col, d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Optionally presents a column in the same cycle; start must win and drop it.
  task automatic do_start(input bit with_col, input int col);
    bus.start    = 1'b1;
    bus.in_valid = with_col;
    bus.in_col   = 5'(col);
    bus.in_data  = rand_col();
    m_active = 1'b1;
    m_exp    = 1;
    m_err    = 1'b0;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_col_error();
    check("col_error", {31'd0, bus.col_error}, {31'd0, m_err});
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_col_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        int  c;
        bit  dn;
        c  = exp_col_q.pop_front();
        dn = exp_done_q.pop_front();
        check("out_col", {27'd0, bus.out_col}, 32'(c));
        check("frame_done", {31'd0, bus.frame_done}, {31'd0, dn});
        for (int p = 0; p < POOL; p++)
          check($sformatf("out_data[%0d]", p), {16'd0, bus.out_data[p]},
                {16'd0, exp_data_q.pop_front()});
      end
    end else begin
      check("frame_done_alone", {31'd0, bus.frame_done}, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    col_t d1, d2;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_col   = '0;
    bus.in_data  = '{default: 16'h0000};

    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_col", {27'd0, bus.out_col}, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_col_error", {31'd0, bus.col_error}, 32'd0);
    check("rst_out_data0", {16'd0, bus.out_data[0]}, 32'd0);
    check("rst_out_data11", {16'd0, bus.out_data[POOL-1]}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Columns before any start are ignored.
    send_col(1, ramp_col(1));
    send_col(2, ramp_col(2));
    idle(2);
    check_col_error();

    // Ramp frame, back-to-back columns.
    do_start(1'b0, 0);
    for (int c = 1; c <= IN; c++) send_col(c, ramp_col(c));
    idle(2);
    check_col_error();

    // Negative pair and signed-zero tie pair.
    do_start(1'b0, 0);
    d1 = rand_col(); d1[0] = 16'hC000; d1[1] = 16'hBC00;
    d2 = rand_col(); d2[0] = 16'hC200; d2[1] = 16'hB800;
    send_col(1, d1);
    send_col(2, d2);
    d1 = rand_col(); d1[0] = 16'h8000; d1[1] = 16'h0000;
    d2 = rand_col(); d2[0] = 16'h8000; d2[1] = 16'h8000;
    send_col(3, d1);
    send_col(4, d2);
    idle(2);

    // Out-of-sequence column; sticky error; output from the column before start still issues.
    do_start(1'b0, 0);
    send_col(1, rand_col());
    send_col(3, rand_col());
    idle(2);
    check_col_error();
    send_col(2, rand_col());
    send_col(3, rand_col());
    send_col(4, rand_col());
    check_col_error();
    do_start(1'b0, 0);
    idle(1);
    check_col_error();

    // Abort mid-pair (start beats a same-cycle column 1), then a clean frame.
    do_start(1'b0, 0);
    for (int c = 1; c <= 5; c++) send_col(c, rand_col());
    do_start(1'b1, 1);
    for (int c = 1; c <= IN; c++) send_col(c, rand_col());
    idle(2);
    check_col_error();

    // Randomized frames with idle gaps and occasional stray columns.
    for (int f = 0; f < 4; f++) begin
      do_start(1'b0, 0);
      for (int c = 1; c <= IN; c++) begin
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) send_col(int'($urandom_range(1, IN)), rand_col());
        send_col(c, rand_col());
      end
      idle(2);
      check_col_error();
    end

    // Async reset while the column-2 output is being presented.
    do_start(1'b0, 0);
    send_col(1, rand_col());
    send_col(2, rand_col());
    rst = 1'b1;
    m_active = 1'b0;
    m_err    = 1'b0;
    exp_col_q.delete();
    exp_done_q.delete();
    exp_data_q.delete();
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("arst_out_data0", {16'd0, bus.out_data[0]}, 32'd0);
    check("arst_out_col", {27'd0, bus.out_col}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_col(1, rand_col());
    send_col(2, rand_col());
    idle(2);
    do_start(1'b0, 0);
    send_col(1, rand_col());
    send_col(2, rand_col());
    idle(4);
    check_col_error();
    check("scoreboard_empty", 32'(exp_col_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
